// File: rtl/bcd_display_formatter.sv
// ---------------------------------------------------------------------------
// bcd_display_formatter
//
// Purpose:
//   Converts an unsigned 27-bit binary value into eight packed BCD digits for
//   the 8-digit seven-segment display controller. The conversion is an
//   iterative double-dabble (shift-and-add-3) loop that takes 27 cycles. It is
//   followed by one DONE cycle in which the result is published.
//   Values above 99_999_999 cannot be shown on eight digits. For those values
//   the output saturates to all nines and overflow_out is raised.
//
// Ports:
//   clk_in        in   1   system clock, rising-edge active
//   rst_in        in   1   synchronous, active-high reset
//   value_in      in  27   binary value, sampled only when a request is accepted
//   valid_in      in   1   request strobe, accepted when busy_out is low
//   busy_out      out  1   conversion in progress or completing (state != IDLE)
//   bcd_out       out 32   last completed result, digit 0 in [3:0]; held
//   valid_out     out  1   one-cycle pulse when bcd_out first shows a new result
//   overflow_out  out  1   last completed result was saturated; held with bcd_out
//
// Handshake: a request is taken on the rising edge where valid_in=1 and
// busy_out=0. If valid_in is high while busy_out=1, the request is dropped
// with no effect. The result is never back-pressured: valid_out is a single
// pulse, and bcd_out/overflow_out keep their values until the next result.
// ---------------------------------------------------------------------------
module bcd_display_formatter (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [26:0] value_in,
   input  logic        valid_in,
   output logic        busy_out,
   output logic [31:0] bcd_out,
   output logic        valid_out,
   output logic        overflow_out
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [26:0] MAX_DISPLAYABLE = 27'd99_999_999;
   localparam logic [31:0] SATURATED_BCD   = 32'h9999_9999;
   localparam logic [4:0]  LAST_ITERATION  = 5'd26;

   state_t      state_q, state_d;
   logic [26:0] bin_q, bin_d;          // binary shift register, MSB first
   logic [31:0] work_q, work_d;        // BCD working register
   logic [4:0]  cnt_q, cnt_d;          // iteration counter
   logic        ovf_q, ovf_d;          // overflow flag of the accepted value
   logic [31:0] bcd_q, bcd_d;          // published result
   logic        ovf_out_q, ovf_out_d;  // published overflow flag

   logic [31:0] adj;                   // working register after add-3 step
   logic [31:0] shifted_work;          // BCD half of the shifted concatenation

   // Add-3 correction: each nibble that is 5 or more gets 3 added, so that
   // doubling it carries correctly into the next decimal digit. The largest
   // possible result is 9 + 3 = 12, which still fits in four bits.
   always_comb begin
      adj = work_q;
      for (int i = 0; i < 8; i++) begin
         if (work_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // {adj, bin} shifted left by one: the binary MSB enters the BCD LSB.
   assign shifted_work = {adj[30:0], bin_q[26]};

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      bcd_d     = bcd_q;
      ovf_out_d = ovf_out_q;

      case (state_q)
         IDLE: begin
            if (valid_in) begin
               bin_d   = value_in;
               work_d  = 32'h0000_0000;
               cnt_d   = 5'd0;
               ovf_d   = (value_in > MAX_DISPLAYABLE);
               state_d = CONVERT;
            end
         end

         CONVERT: begin
            work_d = shifted_work;
            bin_d  = {bin_q[25:0], 1'b0};
            cnt_d  = cnt_q + 5'd1;
            // Overflowing values still run every iteration so that latency is
            // uniform. Their working result is replaced by all nines here.
            if (cnt_q == LAST_ITERATION) begin
               state_d   = DONE;
               bcd_d     = ovf_q ? SATURATED_BCD : shifted_work;
               ovf_out_d = ovf_q;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         bin_q     <= 27'd0;
         work_q    <= 32'h0000_0000;
         cnt_q     <= 5'd0;
         ovf_q     <= 1'b0;
         bcd_q     <= 32'h0000_0000;
         ovf_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         bcd_q     <= bcd_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   assign busy_out     = (state_q != IDLE);
   assign valid_out    = (state_q == DONE);
   assign bcd_out      = bcd_q;
   assign overflow_out = ovf_out_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_formatter
//
// Self-checking bench for bcd_display_formatter. Inputs are driven 1 ns after
// each rising edge, and outputs are sampled in the same window. The expected
// digits come from a decimal split (repeated % 10 and / 10) of the requested
// value, with saturation to all nines above 99_999_999.
// ---------------------------------------------------------------------------
module tb_bcd_display_formatter;

   logic        clk_in;
   logic        rst_in;
   logic [26:0] value_in;
   logic        valid_in;
   logic        busy_out;
   logic [31:0] bcd_out;
   logic        valid_out;
   logic        overflow_out;

   int n_checks;
   int n_errors;

   // Model of the held outputs (last completed result)
   logic [31:0] last_bcd;
   logic        last_ovf;

   bcd_display_formatter dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .value_in     (value_in),
      .valid_in     (valid_in),
      .busy_out     (busy_out),
      .bcd_out      (bcd_out),
      .valid_out    (valid_out),
      .overflow_out (overflow_out)
   );

   // ---------------- clock ----------------
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: decimal digit split of the value
   function automatic logic [31:0] ref_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = 32'h0;
      if (v > 99_999_999) return 32'h9999_9999;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Runs one request accepted in the current cycle (T).
   //   ign_a, ign_b : cycle offsets at which a spurious valid_in pulse is driven (0 = none)
   //   rst_at       : cycle offset at which rst_in is held for one cycle (0 = none)
   task automatic run_one(input logic [26:0] v, input int ign_a, input int ign_b,
                          input int rst_at);
      logic [31:0] exp_bcd;
      logic        exp_ovf;
      int          early_valid;
      int          busy_low;
      int          hold_bad;
      int          late_valid;
      exp_bcd     = ref_bcd(int'(v));
      exp_ovf     = (int'(v) > 99_999_999);
      early_valid = 0;
      busy_low    = 0;
      hold_bad    = 0;

      // cycle T
      check("busy_before_req", {31'd0, busy_out}, 32'd0);
      value_in = v;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      value_in = 27'($urandom);

      // cycles T+1 .. T+27
      for (int k = 1; k < 28; k++) begin
         if (valid_out) early_valid++;
         if (!busy_out) busy_low++;
         if (bcd_out !== last_bcd || overflow_out !== last_ovf) hold_bad++;
         if (k == rst_at) begin
            rst_in   = 1'b1;
            valid_in = 1'b1;
            tick();
            rst_in   = 1'b0;
            valid_in = 1'b0;
            check("rst_mid_busy", {31'd0, busy_out}, 32'd0);
            check("rst_mid_valid", {31'd0, valid_out}, 32'd0);
            check("rst_mid_bcd", bcd_out, 32'h0);
            check("rst_mid_ovf", {31'd0, overflow_out}, 32'd0);
            check("rst_pre_early_valid", early_valid, 0);
            late_valid = 0;
            for (int j = 0; j < 35; j++) begin
               if (valid_out) late_valid++;
               tick();
            end
            check("rst_no_valid_after", late_valid, 0);
            last_bcd = 32'h0;
            last_ovf = 1'b0;
            return;
         end
         if (k == ign_a || k == ign_b) begin
            valid_in = 1'b1;
            value_in = 27'($urandom);
         end
         tick();
         valid_in = 1'b0;
      end

      // cycle T+28 (DONE)
      check("no_early_valid", early_valid, 0);
      check("busy_during_conv", busy_low, 0);
      check("bcd_held_during_conv", hold_bad, 0);
      check("done_valid", {31'd0, valid_out}, 32'd1);
      check("done_busy", {31'd0, busy_out}, 32'd1);
      check("done_bcd", bcd_out, exp_bcd);
      check("done_ovf", {31'd0, overflow_out}, {31'd0, exp_ovf});
      if (ign_b == 28 || ign_a == 28) begin
         valid_in = 1'b1;
         value_in = 27'($urandom);
      end
      tick();
      valid_in = 1'b0;

      // cycle T+29
      check("after_valid_low", {31'd0, valid_out}, 32'd0);
      check("after_busy_low", {31'd0, busy_out}, 32'd0);
      check("after_bcd_held", bcd_out, exp_bcd);
      last_bcd = exp_bcd;
      last_ovf = exp_ovf;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int idle_valid;
      n_checks = 0;
      n_errors = 0;
      rst_in   = 1'b1;
      valid_in = 1'b0;
      value_in = 27'd0;
      last_bcd = 32'h0;
      last_ovf = 1'b0;
      tick();
      tick();
      tick();
      rst_in = 1'b0;

      check("reset_busy", {31'd0, busy_out}, 32'd0);
      check("reset_valid", {31'd0, valid_out}, 32'd0);
      check("reset_bcd", bcd_out, 32'h0);
      check("reset_ovf", {31'd0, overflow_out}, 32'd0);

      run_one(27'd0, 0, 0, 0);
      run_one(27'd12_345_678, 0, 0, 0);
      check("dir_1234_5678", last_bcd, 32'h1234_5678);
      run_one(27'd907, 0, 0, 0);
      run_one(27'd99_999_999, 0, 0, 0);
      run_one(27'd100_000_000, 0, 0, 0);
      run_one(27'h7FF_FFFF, 0, 0, 0);
      run_one(27'd5, 0, 0, 0);

      // Spurious requests at T+5 and at DONE, then 77 right at T+29
      run_one(27'd42, 5, 28, 0);
      run_one(27'd77, 0, 0, 0);

      // Reset mid-conversion (valid_in also high in the reset cycle)
      run_one(27'd31_415_926, 0, 0, 10);
      run_one(27'd8, 0, 0, 0);

      // Reset and valid_in together while idle: reset wins
      rst_in   = 1'b1;
      valid_in = 1'b1;
      value_in = 27'd123;
      tick();
      rst_in   = 1'b0;
      valid_in = 1'b0;
      check("rst_and_req_busy", {31'd0, busy_out}, 32'd0);
      idle_valid = 0;
      for (int j = 0; j < 32; j++) begin
         if (valid_out || busy_out) idle_valid++;
         tick();
      end
      check("rst_and_req_ignored", idle_valid, 0);
      last_bcd = 32'h0;
      last_ovf = 1'b0;

      // Randomised sweep over the displayable range
      for (int i = 0; i < 1000; i++) begin
         run_one(27'($urandom_range(99_999_999, 0)), 0, 0, 0);
      end
      // A few over-range values
      for (int i = 0; i < 20; i++) begin
         run_one(27'($urandom_range(134_217_727, 100_000_000)), 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_display_formatter.md
# bcd_display_formatter

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment display controller. It accepts an unsigned 27-bit binary value on a valid pulse and converts it with an iterative double-dabble (shift-and-add-3) loop. It then presents eight packed BCD digits on a held 32-bit output that wires straight into the display controller's 32-bit value input. Digit 0 (least significant) is in bits [3:0], and digit 7 is in bits [31:28].

## Interface
Parameters: none. Widths are fixed by the 8-digit display.

Ports:
- `clk_in`  input  1  system clock; all state changes on rising edge
- `rst_in`  input  1  synchronous, active-high reset
- `value_in`  input  27  unsigned binary value to convert; sampled only on an accepted request
- `valid_in`  input  1  request strobe; accepted when high while `busy_out` is low
- `busy_out`  output  1  high whenever a conversion is in progress or completing; requests are ignored while high
- `bcd_out`  output  32  eight packed BCD digits of the last completed result; held between conversions
- `valid_out`  output  1  single-cycle pulse marking the cycle in which `bcd_out` first carries a new result
- `overflow_out`  output  1  high if the last completed result was saturated; updates together with `bcd_out`

## Operation
- FSM states and transitions:
  - IDLE: on `valid_in`=1, go to CONVERT.
  - CONVERT: lasts exactly 27 cycles, then go to DONE.
  - DONE: lasts 1 cycle, then go to IDLE.
- `busy_out` = (state != IDLE), taken directly from the state register.
- On acceptance in IDLE, the block performs all of the following on the same edge:
  - Loads `value_in` into a 27-bit shift register.
  - Clears a 32-bit BCD working register.
  - Clears a 5-bit iteration counter.
  - Latches an overflow flag = (`value_in` > 27'd99_999_999).
- Each CONVERT cycle does the following:
  - For each of the 8 working nibbles, computes nibble ≥ 5 ? nibble + 3 : nibble. This is combinational, and all nibbles are adjusted in the same cycle.
  - Shifts the adjusted {BCD, binary} concatenation left by 1. The binary MSB enters the BCD LSB.
  - Increments the counter.
  - Leaves CONVERT after the iteration where counter == 26.
- Overflowing inputs still run all 27 iterations, so latency is uniform. The working register result is discarded.
- Entering DONE registers the result:
  - `bcd_out` <= overflow ? 32'h9999_9999 : working register.
  - `overflow_out` <= overflow flag.
  - `valid_out` = 1 for that one DONE cycle only.
- `bcd_out` and `overflow_out` hold their values until the next DONE. There is no leading-zero blanking; unused upper digits read 0.
- `valid_in` asserted while `busy_out`=1 is dropped with no queuing and no side effect. `value_in` changes during a conversion have no effect.

## Timing
- Reset values:
  - state = IDLE
  - `busy_out`=0
  - `bcd_out`=32'h0000_0000
  - `valid_out`=0
  - `overflow_out`=0
  - working registers and counter = 0
- Cycle-level sequence, with request accepted at cycle T (`valid_in`=1, `busy_out`=0):
  - `busy_out`=1 in cycles T+1 through T+28.
  - The 27 CONVERT iterations occupy cycles T+1 through T+27.
  - DONE is cycle T+28: `valid_out`=1, and the new `bcd_out`/`overflow_out` are visible.
  - `busy_out`=0 in cycle T+29, so the earliest next acceptance is T+29.
- Latency: 28 cycles from request to `valid_out`. Throughput: 1 conversion per 29 cycles.
- A `valid_in` pulse that coincides with DONE is ignored.
- Reset mid-conversion: on the next edge the FSM returns to IDLE and all outputs take their reset values, including clearing `bcd_out`. No `valid_out` is produced for the aborted request.
- Reset and `valid_in` high in the same cycle: reset wins, and the request is not accepted.

## Test plan
- Reset, then request `value_in`=0 → `valid_out` exactly 28 cycles later; `bcd_out`=32'h0000_0000; `overflow_out`=0.
- Request 12_345_678 → `bcd_out`=32'h1234_5678. Then request 907 → 32'h0000_0907. `bcd_out` must stay 32'h1234_5678 until the second `valid_out`.
- Boundaries:
  - 99_999_999 → 32'h9999_9999, `overflow_out`=0.
  - 100_000_000 → 32'h9999_9999, `overflow_out`=1.
  - 27'h7FF_FFFF → 32'h9999_9999, `overflow_out`=1.
  - Then 5 → 32'h0000_0005, `overflow_out`=0.
- Request 42, then pulse `valid_in` with value 77 at T+5 and at T+28 → exactly one `valid_out`, at T+28; `bcd_out`=32'h0000_0042; `busy_out` low at T+29. A request of 77 at T+29 yields 32'h0000_0077 at T+57.
- Request 31_415_926, assert `rst_in` at T+10 for one cycle → no `valid_out`; `bcd_out`=0; `busy_out`=0 the cycle after reset. A fresh request of 8 returns 32'h0000_0008 after 28 cycles.
- Randomised sweep of 1000 values in 0..99_999_999, compared against a reference model of the decimal digit split → every result matches, and `valid_out` is a 1-cycle pulse every time.
